// File: rtl/vga_pixel_out.sv
// VGA raster timing and pixel output stage fed from the pixel FIFO.
// Define VGA_PIX_UNDERFLOW_CNT_EN to add the UNDERFLOW_CNT_OUT pixel counter.
module vga_pixel_out #(
    parameter int                    H_ACTIVE  = 640,
    parameter int                    H_FP      = 16,
    parameter int                    H_SYNC    = 96,
    parameter int                    H_BP      = 48,
    parameter int                    V_ACTIVE  = 480,
    parameter int                    V_FP      = 10,
    parameter int                    V_SYNC    = 2,
    parameter int                    V_BP      = 33,
    parameter bit                    HS_POL    = 1'b0,
    parameter bit                    VS_POL    = 1'b0,
    parameter int                    DATA_SIZE = 24,
    parameter logic [DATA_SIZE-1:0]  UF_COLOUR = 24'hFF00FF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE_IN,
    input  logic [DATA_SIZE-1:0] FIFO_DATA_IN,
    input  logic                 FIFO_EMPTY_IN,
    output logic                 FIFO_RD_OUT,
    output logic [DATA_SIZE-1:0] VGA_RGB_OUT,
    output logic                 VGA_HS_OUT,
    output logic                 VGA_VS_OUT,
    output logic                 VGA_DE_OUT,
    output logic                 FRAME_START_OUT,
    output logic                 UNDERFLOW_OUT
`ifdef VGA_PIX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]          UNDERFLOW_CNT_OUT
`endif
);

    localparam logic [10:0] H_TOT  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_TOT  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0]          r_h_cnt;
    logic [10:0]          r_v_cnt;
    logic                 r_de1;
    logic                 r_uf1;
    logic                 r_hs1;
    logic                 r_vs1;
    logic [DATA_SIZE-1:0] r_rgb;
    logic                 r_de;
    logic                 r_hs;
    logic                 r_vs;
    logic                 r_uf;

    logic w_act;
    logic w_hs;
    logic w_vs;
    logic w_frame_start;

    assign w_act = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs  = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    assign w_vs  = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

    assign w_frame_start = ~RST & ENABLE_IN
                         & (r_h_cnt == 11'd0) & (r_v_cnt == 11'd0);

    assign FIFO_RD_OUT     = ~RST & ENABLE_IN & w_act & ~FIFO_EMPTY_IN;
    assign FRAME_START_OUT = w_frame_start;

    // Disabling parks the raster at the origin so re-enable starts a frame.
    always_ff @(posedge CLK) begin
        if (RST || !ENABLE_IN) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_TOT - 11'd1) begin
            r_h_cnt <= '0;
            if (r_v_cnt == V_TOT - 11'd1) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !ENABLE_IN) begin
            r_de1 <= 1'b0;
            r_uf1 <= 1'b0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
        end else begin
            r_de1 <= w_act;
            r_uf1 <= w_act & FIFO_EMPTY_IN;
            r_hs1 <= w_hs;
            r_vs1 <= w_vs;
        end
    end

    // FIFO read data lands here one cycle after its pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rgb <= '0;
            r_de  <= 1'b0;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
        end else begin
            r_de  <= r_de1;
            r_rgb <= r_de1 ? (r_uf1 ? UF_COLOUR : FIFO_DATA_IN) : '0;
            r_hs  <= r_hs1 ? HS_POL : ~HS_POL;
            r_vs  <= r_vs1 ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_uf <= 1'b0;
        end else if (r_uf1) begin
            r_uf <= 1'b1;
        end else if (w_frame_start) begin
            r_uf <= 1'b0;
        end
    end

    assign VGA_RGB_OUT   = r_rgb;
    assign VGA_DE_OUT    = r_de;
    assign VGA_HS_OUT    = r_hs;
    assign VGA_VS_OUT    = r_vs;
    assign UNDERFLOW_OUT = r_uf;

`ifdef VGA_PIX_UNDERFLOW_CNT_EN
    logic [15:0] r_uf_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_uf_cnt <= '0;
        end else if (r_uf1 && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    assign UNDERFLOW_CNT_OUT = r_uf_cnt;
`endif

endmodule
